a2d_scan_intf: RTL

Parametrised successor to the single-shot A2D SPI interface. Drives an ADC128S-compatible 8-channel SPI ADC in two modes:
- **Single:** one conversion per `strt_cnv`.
- **Scan:** autonomous round-robin over a channel mask.

Every result goes into a per-channel result bank readable at any time. It sits between the ADC pins and the sensor/control logic that previously used the single-shot interface.

---
 rtl/a2d_pkg.sv | 26 ++
 rtl/a2d_spi_frame.sv | 72 +++++++
 rtl/a2d_scan_intf.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/a2d_pkg.sv
// Shared types and constants for the scanning A2D SPI interface.
package a2d_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FRM1,
      ST_GAP,
      ST_FRM2,
      ST_DONE
   } a2d_state_e;

   localparam int FRAME_BITS = 16;
   localparam int RES_W      = 12;
   localparam int CH_W       = 3;
   localparam int ADDR_LSB   = 11;

   // Lowest set bit of mask at index >= lo; returns {found, index}.
   function automatic logic [CH_W:0] find_set(input logic [7:0] mask, input logic [CH_W:0] lo);
      logic [CH_W:0] r;
      r = '0;
      for (int i = 7; i >= 0; i--)
         if (mask[i] && (i >= int'(lo))) r = {1'b1, CH_W'(i)};
      return r;
   endfunction

endpackage

// File: rtl/a2d_spi_frame.sv
// One 16-bit SPI frame, mode 3: SCLK idles high, MOSI shifts on the falling edge, MISO captured on the rising edge.
module a2d_spi_frame
   import a2d_pkg::*;
#(
   parameter int SCLK_DIV = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [FRAME_BITS-1:0] tx_word,
   input  logic                  miso,
   output logic [FRAME_BITS-1:0] rx_word,
   output logic                  frm_done,
   output logic                  ss_n,
   output logic                  sclk,
   output logic                  mosi
);

   localparam int H      = SCLK_DIV / 2;
   localparam int HW     = $clog2(H);
   localparam int HALVES = 2 * FRAME_BITS;

   logic                  active;
   logic [HW-1:0]         hcnt;
   logic [5:0]            half;
   logic [FRAME_BITS-1:0] tx_sh;
   logic                  half_end;

   // Half 0 is the setup phase; odd halves are SCLK low, even halves high.
   assign half_end = (hcnt == HW'(H - 1));
   assign frm_done = active && half_end && (half == 6'(HALVES));

   always_ff @(posedge clk) begin
      if (rst) begin
         active  <= 1'b0;
         hcnt    <= '0;
         half    <= '0;
         tx_sh   <= '0;
         rx_word <= '0;
         ss_n    <= 1'b1;
         sclk    <= 1'b1;
         mosi    <= 1'b0;
      end else if (!active) begin
         if (start) begin
            active <= 1'b1;
            hcnt   <= '0;
            half   <= '0;
            ss_n   <= 1'b0;
            tx_sh  <= tx_word;
         end
      end else if (!half_end) begin
         hcnt <= hcnt + HW'(1);
      end else begin
         hcnt <= '0;
         if (half == 6'(HALVES)) begin
            active <= 1'b0;
            ss_n   <= 1'b1;
         end else begin
            half <= half + 6'd1;
            if (!half[0]) begin
               sclk  <= 1'b0;
               mosi  <= tx_sh[FRAME_BITS-1];
               tx_sh <= {tx_sh[FRAME_BITS-2:0], 1'b0};
            end else begin
               sclk    <= 1'b1;
               rx_word <= {rx_word[FRAME_BITS-2:0], miso};
            end
         end
      end
   end

endmodule

// File: rtl/a2d_scan_intf.sv
// ADC128S-style A2D interface: single conversions or round-robin scan over a channel mask,
// with a per-channel result bank.
module a2d_scan_intf
   import a2d_pkg::*;
#(
   parameter int SCLK_DIV = 32,
   parameter int NUM_CH   = 8,
   parameter int RES_INV  = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              strt_cnv,
   input  logic [CH_W-1:0]   chnnl,
   input  logic              scan_en,
   input  logic [NUM_CH-1:0] scan_mask,
   input  logic [CH_W-1:0]   rd_ch,
   output logic [RES_W-1:0]  rd_res,
   output logic [RES_W-1:0]  res,
   output logic [CH_W-1:0]   res_ch,
   output logic              cnv_cmplt,
   output logic              scan_done,
   output logic              busy,
   output logic              a2d_SS_n,
   output logic              SCLK,
   output logic              MOSI,
   input  logic              MISO
);

   localparam int GW = $clog2(SCLK_DIV);

   a2d_state_e            state;
   logic [CH_W-1:0]       cur_ch;
   logic                  scan_mode;
   logic [GW-1:0]         gap_cnt;
   logic [RES_W-1:0]      bank [NUM_CH];

   logic [7:0]            mask8;
   logic [CH_W:0]         scan_lo;
   logic [CH_W:0]         scan_nx;
   logic                  gap_last;
   logic                  start;
   logic [CH_W-1:0]       nxt_ch;
   logic [FRAME_BITS-1:0] tx_word;
   logic [FRAME_BITS-1:0] rx_word;
   logic                  frm_done;
   logic [RES_W-1:0]      cnv_val;
   logic                  unused_rx;

   assign mask8     = 8'(scan_mask);
   assign scan_lo   = find_set(mask8, '0);
   assign scan_nx   = find_set(mask8, {1'b0, cur_ch} + (CH_W+1)'(1));
   assign gap_last  = (gap_cnt == GW'(SCLK_DIV - 1));
   assign tx_word   = {2'b00, nxt_ch, {ADDR_LSB{1'b0}}};
   assign cnv_val   = (RES_INV != 0) ? ~rx_word[RES_W-1:0] : rx_word[RES_W-1:0];
   assign unused_rx = &{1'b0, rx_word[FRAME_BITS-1:RES_W]};

   // Frame launch is combinational so the frame starts on the same edge the FSM leaves IDLE/GAP/DONE.
   always_comb begin
      start  = 1'b0;
      nxt_ch = cur_ch;
      case (state)
         ST_IDLE: begin
            if (strt_cnv) begin
               start  = 1'b1;
               nxt_ch = chnnl;
            end else if (scan_en && scan_lo[CH_W]) begin
               start  = 1'b1;
               nxt_ch = scan_lo[CH_W-1:0];
            end
         end
         ST_GAP:  start = gap_last;
         ST_DONE: begin
            if (scan_mode && scan_en && scan_lo[CH_W]) begin
               start  = 1'b1;
               nxt_ch = scan_nx[CH_W] ? scan_nx[CH_W-1:0] : scan_lo[CH_W-1:0];
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         cur_ch    <= '0;
         scan_mode <= 1'b0;
         gap_cnt   <= '0;
         res       <= '0;
         res_ch    <= '0;
         cnv_cmplt <= 1'b0;
         scan_done <= 1'b0;
         busy      <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) bank[i] <= '0;
      end else begin
         cnv_cmplt <= 1'b0;
         scan_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state     <= ST_FRM1;
                  cur_ch    <= nxt_ch;
                  scan_mode <= !strt_cnv;
                  busy      <= 1'b1;
               end
            end
            ST_FRM1: begin
               if (frm_done) begin
                  state   <= ST_GAP;
                  gap_cnt <= '0;
               end
            end
            ST_GAP: begin
               if (gap_last) state <= ST_FRM2;
               else          gap_cnt <= gap_cnt + GW'(1);
            end
            ST_FRM2: begin
               if (frm_done) begin
                  state     <= ST_DONE;
                  res       <= cnv_val;
                  res_ch    <= cur_ch;
                  cnv_cmplt <= 1'b1;
                  scan_done <= scan_mode && scan_en && scan_lo[CH_W] && !scan_nx[CH_W];
               end
            end
            ST_DONE: begin
               // Out-of-range single-conversion channels match no entry and leave the bank alone.
               for (int i = 0; i < NUM_CH; i++)
                  if (res_ch == CH_W'(i)) bank[i] <= res;
               if (start) begin
                  state  <= ST_FRM1;
                  cur_ch <= nxt_ch;
               end else begin
                  state     <= ST_IDLE;
                  busy      <= 1'b0;
                  scan_mode <= 1'b0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      rd_res = '0;
      for (int i = 0; i < NUM_CH; i++)
         if (rd_ch == CH_W'(i)) rd_res = bank[i];
   end

   a2d_spi_frame #(.SCLK_DIV(SCLK_DIV)) u_frame (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .tx_word  (tx_word),
      .miso     (MISO),
      .rx_word  (rx_word),
      .frm_done (frm_done),
      .ss_n     (a2d_SS_n),
      .sclk     (SCLK),
      .mosi     (MOSI)
   );

endmodule
